// File: rtl/xil_prim_pkg.sv
// rtl/xil_prim_pkg.sv - shared primitive types: iserdes aligner state encoding and lock threshold
package xil_prim_pkg;

  typedef enum logic [1:0] {
    AL_HUNT   = 2'd0,
    AL_SLIP   = 2'd1,
    AL_WAIT   = 2'd2,
    AL_LOCKED = 2'd3
  } align_state_e;

  localparam int ALIGN_MATCHES = 4;
  localparam int ALIGN_CNT_W   = $clog2(ALIGN_MATCHES);

endpackage

// File: rtl/iserdes_sdr_align.sv
// rtl/iserdes_sdr_align.sv - training-word aligner; slips the deserializer until TRAIN_PATTERN repeats
module iserdes_sdr_align
  import xil_prim_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] TRAIN_PATTERN = 8'h5C
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic                  q_valid_i,
  input  logic                  slip_block_i,
  output logic                  slip_o,
  output logic                  aligned_o
);

  align_state_e             state_q, state_d;
  logic [ALIGN_CNT_W-1:0]   match_q, match_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= AL_HUNT;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    slip_o    = 1'b0;
    aligned_o = 1'b0;
    unique case (state_q)
      AL_HUNT: begin
        if (q_valid_i) begin
          if (q_i == TRAIN_PATTERN[DATA_WIDTH-1:0]) begin
            if (match_q == ALIGN_CNT_W'(ALIGN_MATCHES - 1)) state_d = AL_LOCKED;
            else                                            match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
            state_d = AL_SLIP;
          end
        end
      end
      // Hold the pulse until an enabled edge can actually take it.
      AL_SLIP: begin
        slip_o = 1'b1;
        if (ce_i) state_d = AL_WAIT;
      end
      AL_WAIT: begin
        if (!slip_block_i) state_d = AL_HUNT;
      end
      AL_LOCKED: aligned_o = 1'b1;
      default:   state_d = AL_HUNT;
    endcase
  end

endmodule

// File: rtl/iserdes_sdr.sv
// rtl/iserdes_sdr.sv - SDR serial-to-parallel deserializer with bitslip; ISERDES_SDR_ALIGN_EN adds the training aligner
module iserdes_sdr #(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] INIT_Q        = 8'h00,
  parameter logic [7:0] TRAIN_PATTERN = 8'h5C
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  D,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VALID,
  output logic                  ALIGNED
);

  localparam int            CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  block_q, block_d;
  logic                  seen_q, seen_d;
  logic                  align_slip;
  logic                  slip_take;

`ifdef ISERDES_SDR_ALIGN_EN
  iserdes_sdr_align #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN)
  ) u_align (
    .clk_i        (CLK),
    .rst_i        (RST),
    .ce_i         (CE),
    .q_i          (q_q),
    .q_valid_i    (valid_q),
    .slip_block_i (block_q),
    .slip_o       (align_slip),
    .aligned_o    (ALIGNED)
  );
`else
  // The training word is only consumed by the aligner.
  logic unused_train;
  assign unused_train = ^TRAIN_PATTERN;
  assign align_slip   = 1'b0;
  assign ALIGNED      = 1'b0;
`endif

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    valid_d   = 1'b0;
    block_d   = block_q;
    seen_d    = seen_q;
    slip_take = (BITSLIP | align_slip) & ~block_q;
    if (CE) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], D};
      if (slip_take) begin
        block_d = 1'b1;
        seen_d  = 1'b0;
      end else if (cnt_q == LAST) begin
        cnt_d   = '0;
        q_d     = {shift_q[DATA_WIDTH-2:0], D};
        valid_d = 1'b1;
        // Block releases on the second emitted word after a slip.
        if (block_q) begin
          seen_d = ~seen_q;
          if (seen_q) block_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
      q_q     <= INIT_Q[DATA_WIDTH-1:0];
      valid_q <= 1'b0;
      block_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      block_q <= block_d;
      seen_q  <= seen_d;
    end
  end

  assign Q       = q_q;
  assign Q_VALID = valid_q;

endmodule

// File: tb/tb_iserdes_sdr.sv
// tb/tb_iserdes_sdr.sv - directed self-checking bench for iserdes_sdr (DATA_WIDTH=8, INIT_Q=0)
module tb_iserdes_sdr;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b1;
  logic       D = 1'b0;
  logic       BITSLIP = 1'b0;
  logic [7:0] Q;
  logic       Q_VALID;
  logic       ALIGNED;

  int         nvec = 0;
  int         nbad = 0;
  logic [7:0] pat = 8'hA5;
  int         bitpos = 7;

  iserdes_sdr #(
    .DATA_WIDTH    (8),
    .INIT_Q        (8'h00),
    .TRAIN_PATTERN (8'h5C)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .D       (D),
    .BITSLIP (BITSLIP),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .ALIGNED (ALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic send_bit();
    D = pat[bitpos];
    bitpos = (bitpos == 0) ? 7 : bitpos - 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] p, input int start);
    RST = 1'b1; CE = 1'b1; BITSLIP = 1'b0; D = 1'b0;
    pat = p; bitpos = start;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; BITSLIP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D = i[0];
      @(posedge CLK); #1;
      nvec++;
      if (Q !== 8'h00 || Q_VALID !== 1'b0 || ALIGNED !== 1'b0) begin
        nbad++;
        $display("FAIL reset i=%0d: Q=%h Q_VALID=%b ALIGNED=%b, expected Q=00 Q_VALID=0 ALIGNED=0",
                 i, Q, Q_VALID, ALIGNED);
      end
    end
  endtask

  task automatic test_stream();
    logic       exp_v;
    logic [7:0] exp_q;
    do_reset(8'hA5, 7);
    for (int e = 1; e <= 32; e++) begin
      send_bit();
      exp_v = (e % 8 == 0);
      exp_q = (e >= 8) ? 8'hA5 : 8'h00;
      nvec++;
      if (Q_VALID !== exp_v || Q !== exp_q) begin
        nbad++;
        $display("FAIL stream e=%0d: Q=%h Q_VALID=%b, expected Q=%h Q_VALID=%b",
                 e, Q, Q_VALID, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_bitslip();
    logic       exp_v;
    logic [7:0] exp_q;
    do_reset(8'hA5, 7);
    repeat (8) send_bit();
    for (int e = 1; e <= 26; e++) begin
      BITSLIP = (e == 1 || e == 4);
      send_bit();
      BITSLIP = 1'b0;
      exp_v = (e == 9 || e == 17 || e == 25);
      exp_q = (e >= 9) ? 8'h4B : 8'hA5;
      nvec++;
      if (Q_VALID !== exp_v || Q !== exp_q) begin
        nbad++;
        $display("FAIL bitslip e=%0d: Q=%h Q_VALID=%b, expected Q=%h Q_VALID=%b",
                 e, Q, Q_VALID, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_slip_last();
    do_reset(8'hA5, 7);
    repeat (7) send_bit();
    BITSLIP = 1'b1;
    send_bit();
    BITSLIP = 1'b0;
    nvec++;
    if (Q_VALID !== 1'b0 || Q !== 8'h00) begin
      nbad++;
      $display("FAIL slip_last suppressed: Q=%h Q_VALID=%b, expected Q=00 Q_VALID=0", Q, Q_VALID);
    end
    send_bit();
    nvec++;
    if (Q_VALID !== 1'b1 || Q !== 8'h4B) begin
      nbad++;
      $display("FAIL slip_last late word: Q=%h Q_VALID=%b, expected Q=4b Q_VALID=1", Q, Q_VALID);
    end
  endtask

  task automatic test_slip_restore();
    logic [7:0] exp_q;
    int         seen;
    int         guard;
    do_reset(8'hA5, 7);
    repeat (8) send_bit();
    exp_q = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      BITSLIP = 1'b1;
      send_bit();
      BITSLIP = 1'b0;
      seen = 0; guard = 0;
      while (seen < 2 && guard < 40) begin
        send_bit();
        guard++;
        if (Q_VALID === 1'b1) seen++;
      end
      exp_q = {exp_q[6:0], exp_q[7]};
      nvec++;
      if (seen != 2 || Q !== exp_q) begin
        nbad++;
        $display("FAIL slip_restore k=%0d: Q=%h words=%0d, expected Q=%h words=2", k, Q, seen, exp_q);
      end
    end
    repeat (8) send_bit();
    nvec++;
    if (Q_VALID !== 1'b1 || Q !== 8'hA5) begin
      nbad++;
      $display("FAIL slip_restore final: Q=%h Q_VALID=%b, expected Q=a5 Q_VALID=1", Q, Q_VALID);
    end
  endtask

  task automatic test_ce_hold();
    do_reset(8'hA5, 7);
    repeat (12) send_bit();
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D = ~i[0];
      @(posedge CLK); #1;
      nvec++;
      if (Q_VALID !== 1'b0 || Q !== 8'hA5) begin
        nbad++;
        $display("FAIL ce_hold i=%0d: Q=%h Q_VALID=%b, expected Q=a5 Q_VALID=0", i, Q, Q_VALID);
      end
    end
    CE = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      send_bit();
      nvec++;
      if (Q_VALID !== (e == 4) || Q !== 8'hA5) begin
        nbad++;
        $display("FAIL ce_resume e=%0d: Q=%h Q_VALID=%b, expected Q=a5 Q_VALID=%b", e, Q, Q_VALID, e == 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q;
    do_reset(8'hA5, 7);
    repeat (12) send_bit();
    #2 RST = 1'b1;
    #1;
    nvec++;
    if (Q !== 8'h00 || Q_VALID !== 1'b0) begin
      nbad++;
      $display("FAIL reset_mid async: Q=%h Q_VALID=%b, expected Q=00 Q_VALID=0", Q, Q_VALID);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    bitpos = 7;
    for (int e = 1; e <= 8; e++) begin
      send_bit();
      exp_q = (e == 8) ? 8'hA5 : 8'h00;
      nvec++;
      if (Q_VALID !== (e == 8) || Q !== exp_q) begin
        nbad++;
        $display("FAIL reset_mid e=%0d: Q=%h Q_VALID=%b, expected Q=%h Q_VALID=%b",
                 e, Q, Q_VALID, exp_q, e == 8);
      end
    end
  endtask

`ifdef ISERDES_SDR_ALIGN_EN
  task automatic test_align();
    int guard;
    int words;
    do_reset(8'h5C, 4);
    guard = 0;
    while (ALIGNED !== 1'b1 && guard < 1500) begin
      send_bit();
      guard++;
    end
    nvec++;
    if (ALIGNED !== 1'b1) begin
      nbad++;
      $display("FAIL align lock: ALIGNED=%b after %0d cycles, expected 1", ALIGNED, guard);
    end
    words = 0; guard = 0;
    while (words < 3 && guard < 40) begin
      send_bit();
      guard++;
      if (Q_VALID === 1'b1) begin
        words++;
        nvec++;
        if (Q !== 8'h5C || ALIGNED !== 1'b1) begin
          nbad++;
          $display("FAIL align word %0d: Q=%h ALIGNED=%b, expected Q=5c ALIGNED=1", words, Q, ALIGNED);
        end
      end
    end
    nvec++;
    if (words != 3) begin
      nbad++;
      $display("FAIL align words: got %0d, expected 3", words);
    end
  endtask
`else
  task automatic test_align_disabled();
    do_reset(8'h5C, 4);
    repeat (64) send_bit();
    nvec++;
    if (ALIGNED !== 1'b0 || Q_VALID !== 1'b1 || Q !== 8'hE2) begin
      nbad++;
      $display("FAIL align_disabled: ALIGNED=%b Q=%h Q_VALID=%b, expected ALIGNED=0 Q=e2 Q_VALID=1",
               ALIGNED, Q, Q_VALID);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ISERDES_SDR_ALIGN_EN
    test_align();
`else
    test_stream();
    test_bitslip();
    test_slip_last();
    test_slip_restore();
    test_ce_hold();
    test_reset_mid();
    test_align_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/iserdes_sdr.md
ISERDES_SDR -- requirements
Module: iserdes_sdr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (legal 2..8).
REQ-002 SHALL have parameter INIT_Q, default 8'h00, Q value after reset (low DATA_WIDTH bits used).
REQ-003 SHALL have parameter TRAIN_PATTERN, default 8'h5C, aligner training word (low DATA_WIDTH bits used).
REQ-004 CLK  input  1  single bit clock, rising edge; all state on this clock.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 CE  input  1  clock enable; low = all state holds.
REQ-007 D  input  1  serial data, driven by the differential input buffer output.
REQ-008 BITSLIP  input  1  request to move the word boundary one bit later.
REQ-009 Q  output  DATA_WIDTH  deserialized word.
REQ-010 Q_VALID  output  1  one-cycle strobe, Q updated this cycle.
REQ-011 ALIGNED  output  1  aligner locked to TRAIN_PATTERN.

Function
REQ-012 Each CE-high cycle SHALL shift D into a DATA_WIDTH shift register; first received bit of a word lands in Q[DATA_WIDTH-1].
REQ-013 Bit counter cnt SHALL count 0..DATA_WIDTH-1 on CE-high cycles, wrapping to 0.
REQ-014 On a CE-high edge with cnt==DATA_WIDTH-1 and no slip taken, Q SHALL load {shift[DATA_WIDTH-2:0],D} and Q_VALID SHALL be 1 for the following cycle only.
REQ-015 Latency: last bit of a word sampled at edge k SHALL be visible on Q, with Q_VALID=1, immediately after edge k.
REQ-016 CE low SHALL freeze shift register, cnt, Q and slip state; Q_VALID SHALL be 0.
REQ-017 BITSLIP (or internal aligner slip) high on a CE-high edge with slip_block==0 SHALL be accepted: cnt does not advance that edge, lengthening the current word by one bit.
REQ-018 Slip accepted on the cnt==DATA_WIDTH-1 edge SHALL suppress that word; word emitted on the next CE-high edge.
REQ-019 Acceptance SHALL set slip_block; slip_block SHALL clear on the second Q_VALID after acceptance; BITSLIP while blocked SHALL be ignored (not queued).
REQ-020 DATA_WIDTH accepted slips SHALL restore the original alignment (modulo wrap).
REQ-021 Q SHALL hold between Q_VALID strobes.

Reset
REQ-022 RST SHALL asynchronously force Q=INIT_Q, Q_VALID=0, ALIGNED=0, cnt=0, shift register=0, slip_block=0, aligner state HUNT.
REQ-023 Reset mid-word SHALL discard the partial word; first word after release SHALL complete DATA_WIDTH CE-high cycles after release.

Configuration
REQ-024 Macro ISERDES_SDR_ALIGN_EN SHALL compile in the training aligner; without it ALIGNED SHALL be tied 0 and only the BITSLIP port causes slips.
REQ-025 Aligner FSM states: HUNT, SLIP, WAIT, LOCKED.
REQ-026 HUNT: on Q_VALID with Q==TRAIN_PATTERN increment match count; 4 consecutive matches -> LOCKED; mismatch -> clear count, go SLIP.
REQ-027 SLIP: issue one internal slip pulse (ORed with BITSLIP) -> WAIT.
REQ-028 WAIT: remain until slip_block clears -> HUNT.
REQ-029 LOCKED: ALIGNED=1, no internal slips; sticky until RST.

Structure
REQ-030 Aligner state encoding and match-count threshold (4) SHALL live in shared package xil_prim_pkg.
REQ-031 Aligner SHALL be sub-module iserdes_sdr_align, instantiated only under ISERDES_SDR_ALIGN_EN.

Verification (DATA_WIDTH=8, INIT_Q=0)
REQ-032 Reset release, CE=1, repeating 0xA5 MSB-first -> Q=0xA5, Q_VALID every 8 cycles, first 8 cycles after release.
REQ-033 One BITSLIP pulse on 0xA5 stream -> one 9-cycle word period, then Q=0x4B every 8 cycles; second BITSLIP within blocked window ignored.
REQ-034 8 accepted slips spaced past slip_block -> Q returns to 0xA5.
REQ-035 CE low 3 cycles at cnt=4 -> Q/Q_VALID frozen, next Q_VALID 3 cycles late, Q=0xA5.
REQ-036 RST pulse at cnt=4 (between edges) -> Q=0x00, Q_VALID=0 immediately; next word 8 cycles after release.
REQ-037 ISERDES_SDR_ALIGN_EN, 0x5C stream offset 3 bits -> automatic slips, ALIGNED=1 after 4 matching words, Q=0x5C thereafter; BITSLIP-only build keeps ALIGNED=0.
